bank_pingpong_sched: RTL and testbench
======================================

BANK_PINGPONG_SCHED -- requirements
Module: bank_pingpong_sched

Interface
REQ-001 SHALL have parameter W_DEPTH, default 16, meaning words per west tile per bank.
REQ-002 SHALL have parameter N_DEPTH, default 16, meaning words per north tile per bank.
REQ-003 SHALL have parameter ADDR_W, default $clog2(max(W_DEPTH,N_DEPTH)), meaning the write address width.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst_n  in  1  synchronous, active-low reset.
REQ-006 w_in_valid / w_in_ready  in / out  1 / 1  west loader handshake.
REQ-007 n_in_valid / n_in_ready  in / out  1 / 1  north loader handshake.
REQ-008 wr_en  out  1  shared bank write strobe.
REQ-009 wr_sel  out  1  write target: 0 = west, 1 = north.
REQ-010 wr_bank  out  1  target bank: 0 = ping, 1 = pong.
REQ-011 wr_addr  out  ADDR_W  word address within the tile.
REQ-012 comp_start  out  1  one-cycle pulse that launches matmul on comp_bank.
REQ-013 comp_bank  out  1  bank currently owned by compute.
REQ-014 comp_busy  out  1  compute running.
REQ-015 comp_done  in  1  acc_done from matmul; a one-cycle pulse.
REQ-016 bank_full  out  2  per-bank: both west and north tiles loaded.

Function
REQ-017 SHALL keep per-bank west count wc[b] (0..W_DEPTH) and north count nc[b] (0..N_DEPTH); bank_full[b] = (wc[b]==W_DEPTH && nc[b]==N_DEPTH), registered.
REQ-018 SHALL keep load_ptr; loading targets bank load_ptr only; the load side is stalled when bank_full[load_ptr]=1.
REQ-019 SHALL compute eligibility combinationally: west eligible = w_in_valid && wc[load_ptr]<W_DEPTH && !bank_full[load_ptr]; north likewise with nc and N_DEPTH.
REQ-020 SHALL grant at most one requester per cycle; w_in_ready/n_in_ready = grant, combinational from valid, counters and rr_last.
REQ-021 SHALL arbitrate round-robin when both are eligible: grant the side not granted last (rr_last); rr_last resets to north so west wins first; a single eligible side is granted regardless of rr_last.
REQ-022 On handshake, SHALL register, 1-cycle latency: wr_en=1, wr_sel=side, wr_bank=load_ptr, wr_addr=count before increment; SHALL increment that count and update rr_last.
REQ-023 SHALL drive wr_en=0 in any cycle without a preceding handshake; wr_sel/wr_bank/wr_addr hold their last values.
REQ-024 When the handshake completes bank load_ptr (both counts at depth), SHALL toggle load_ptr the next cycle; if the new bank is still full/owned by compute, loading stalls (both ready=0) until that bank is freed.
REQ-025 Compute FSM states C_IDLE, C_RUN: C_IDLE->C_RUN when bank_full[comp_bank]=1, pulsing comp_start for exactly that cycle; C_RUN->C_IDLE on comp_done.
REQ-026 On comp_done in C_RUN, SHALL clear wc/nc/bank_full for comp_bank and toggle comp_bank in the same edge; comp_busy = (state==C_RUN).
REQ-027 SHALL ignore comp_done in C_IDLE.
REQ-028 If comp_done frees a bank in the cycle load_ptr points at it, SHALL allow the first write to that bank in the following cycle, never the same cycle.
REQ-029 Both banks full, compute running: both ready=0, wr_en=0; no count shall exceed its depth (saturating guard).
REQ-030 wr_addr SHALL wrap to 0 per tile, per side, per bank; it is never shared across west and north.

Reset
REQ-031 rst_n=0 at an edge SHALL clear: ready outputs 0 (combinationally forced), wr_en 0, wr_sel 0, wr_bank 0, wr_addr 0, comp_start 0, comp_bank 0, comp_busy 0, bank_full 0, all counts 0, load_ptr 0, rr_last=north, FSM C_IDLE.
REQ-032 Reset mid-load or mid-compute SHALL discard all progress; a subsequent comp_done SHALL be ignored.

Structure
REQ-033 The shared buffer package SHALL hold the compute-state enum (C_IDLE, C_RUN) and the WR_SEL_WEST/WR_SEL_NORTH constants.
REQ-034 The 2-way round-robin arbiter SHALL be one sub-module, rr_arb2.
REQ-035 Counters and FSM SHALL remain in bank_pingpong_sched.

Verification (W_DEPTH=4, N_DEPTH=4)
REQ-036 Both valids held high from reset -> grants alternate W,N,W,N...; wr_addr 0,0,1,1,2,2,3,3; bank_full[0]=1 after the 8th write; comp_start pulses once with comp_bank=0.
REQ-037 Only w_in_valid high -> 4 west writes to addr 0..3, then w_in_ready=0 while nc[0]=0; bank_full stays 0.
REQ-038 Fill bank 0 and bank 1, no comp_done -> both ready=0 and wr_en=0 for 20 cycles; comp_start occurs only once.
REQ-039 comp_done on bank 0 while bank 1 is full -> bank_full=2'b10, comp_bank=1, comp_start one cycle later, and loading resumes into bank 0 at addr 0.
REQ-040 rst_n=0 for 1 cycle after 3 writes -> all outputs at reset values; the next first grant is west, wr_addr=0, wr_bank=0.
REQ-041 comp_done pulsed in C_IDLE -> no state change; counts unchanged.

Source files
------------

// File: rtl/bank_pingpong_sched_pkg.sv
// Shared types and constants for the ping-pong bank scheduler.
package bank_pingpong_sched_pkg;

  // Compute-side ownership state
  typedef enum logic {
    C_IDLE = 1'b0,
    C_RUN  = 1'b1
  } comp_state_e;

  // Write target select encoding (also the arbiter request index)
  localparam logic WR_SEL_WEST  = 1'b0;
  localparam logic WR_SEL_NORTH = 1'b1;

  // Elaboration-time helper for sizing address and counter widths
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bank_pingpong_sched_if.sv
// Loader handshakes, shared bank write port and compute control bundle.
interface bank_pingpong_sched_if #(
  parameter int ADDR_W = 4
);
  logic              w_in_valid;
  logic              w_in_ready;
  logic              n_in_valid;
  logic              n_in_ready;
  logic              wr_en;
  logic              wr_sel;
  logic              wr_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic              comp_start;
  logic              comp_bank;
  logic              comp_busy;
  logic              comp_done;
  logic [1:0]        bank_full;

  // Scheduler side
  modport slave (
    input  w_in_valid, n_in_valid, comp_done,
    output w_in_ready, n_in_ready, wr_en, wr_sel, wr_bank, wr_addr,
           comp_start, comp_bank, comp_busy, bank_full
  );

  // Loader / compute / memory side
  modport master (
    output w_in_valid, n_in_valid, comp_done,
    input  w_in_ready, n_in_ready, wr_en, wr_sel, wr_bank, wr_addr,
           comp_start, comp_bank, comp_busy, bank_full
  );
endinterface

// File: rtl/bank_pingpong_sched_rr_arb2.sv
// Two-way round-robin arbiter: bit 0 = west, bit 1 = north.
// When both request, the side not granted last wins; a lone requester
// always wins. The history starts at north so west wins the first tie.
module rr_arb2
  import bank_pingpong_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  logic r_last;  // side granted most recently (WR_SEL_* encoding)

  // Grant selection, purely combinational from requests and history
  always_comb begin
    o_gnt = 2'b00;
    if (i_req == 2'b11) begin
      o_gnt = (r_last == WR_SEL_NORTH) ? 2'b01 : 2'b10;
    end else begin
      o_gnt = i_req;
    end
  end

  // Remember the winner of every granted cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last <= WR_SEL_NORTH;
    end else if (|o_gnt) begin
      r_last <= o_gnt[1];
    end
  end

endmodule

// File: rtl/bank_pingpong_sched.sv
// Ping-pong bank scheduler: two loaders fill the bank at load_ptr through
// one shared write port while compute owns the other bank. A bank is
// handed to compute once both its west and north tiles are loaded, and is
// handed back (cleared) when compute reports done.
module bank_pingpong_sched
  import bank_pingpong_sched_pkg::*;
#(
  parameter int W_DEPTH = 16,
  parameter int N_DEPTH = 16,
  parameter int ADDR_W  = $clog2(max2(W_DEPTH, N_DEPTH))
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bank_pingpong_sched_if.slave  bus
);

  // Counts run 0..DEPTH inclusive, so they need one more code than addresses
  localparam int CNT_W = $clog2(max2(W_DEPTH, N_DEPTH) + 1);
  localparam logic [CNT_W-1:0] W_FULL = CNT_W'(W_DEPTH);
  localparam logic [CNT_W-1:0] N_FULL = CNT_W'(N_DEPTH);

  // Per-bank fill state
  logic [1:0][CNT_W-1:0] r_wc, r_nc;
  logic [1:0][CNT_W-1:0] w_wc_nxt, w_nc_nxt;
  logic [1:0]            r_bank_full, w_bank_full_nxt;
  logic                  r_load_ptr;

  // Registered write port
  logic              r_wr_en, r_wr_sel, r_wr_bank;
  logic [ADDR_W-1:0] r_wr_addr;

  // Compute ownership
  comp_state_e r_state, w_state_nxt;
  logic        r_comp_bank;
  logic        w_comp_start;

  // Load-side arbitration
  logic             w_w_elig, w_n_elig;
  logic [1:0]       w_gnt;
  logic             w_hs, w_side;
  logic [CNT_W-1:0] w_cur_cnt;
  logic             w_done;
  logic             w_lp_complete;

  // A side may load only into a non-full bank and only while its tile has room;
  // reset forces both readies low without waiting for an edge.
  assign w_w_elig = rst_n && bus.w_in_valid && (r_wc[r_load_ptr] < W_FULL)
                    && !r_bank_full[r_load_ptr];
  assign w_n_elig = rst_n && bus.n_in_valid && (r_nc[r_load_ptr] < N_FULL)
                    && !r_bank_full[r_load_ptr];

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .i_req ({w_n_elig, w_w_elig}),
    .o_gnt (w_gnt)
  );

  assign bus.w_in_ready = w_gnt[0];
  assign bus.n_in_ready = w_gnt[1];

  assign w_hs      = |w_gnt;
  assign w_side    = w_gnt[1] ? WR_SEL_NORTH : WR_SEL_WEST;
  assign w_cur_cnt = (w_side == WR_SEL_NORTH) ? r_nc[r_load_ptr] : r_wc[r_load_ptr];
  assign w_done    = bus.comp_done && (r_state == C_RUN);

  // Next counts: bump the granted side of load_ptr, clear the bank compute
  // releases. The two never hit the same bank: a bank owned by compute is
  // full, so nothing is granted into it.
  always_comb begin
    w_wc_nxt = r_wc;
    w_nc_nxt = r_nc;
    if (w_gnt[0]) w_wc_nxt[r_load_ptr] = r_wc[r_load_ptr] + 1'b1;
    if (w_gnt[1]) w_nc_nxt[r_load_ptr] = r_nc[r_load_ptr] + 1'b1;
    if (w_done) begin
      w_wc_nxt[r_comp_bank] = '0;
      w_nc_nxt[r_comp_bank] = '0;
    end
    for (int b = 0; b < 2; b++) begin
      w_bank_full_nxt[b] = (w_wc_nxt[b] == W_FULL) && (w_nc_nxt[b] == N_FULL);
    end
  end

  // The handshake that fills load_ptr's last slot moves loading to the other bank
  assign w_lp_complete = w_hs && w_bank_full_nxt[r_load_ptr];

  // Fill counters, full flags and load pointer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wc        <= '0;
      r_nc        <= '0;
      r_bank_full <= '0;
      r_load_ptr  <= 1'b0;
    end else begin
      r_wc        <= w_wc_nxt;
      r_nc        <= w_nc_nxt;
      r_bank_full <= w_bank_full_nxt;
      if (w_lp_complete) r_load_ptr <= ~r_load_ptr;
    end
  end

  // Write port: one-cycle-late copy of each handshake; address/target hold when idle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_en   <= 1'b0;
      r_wr_sel  <= WR_SEL_WEST;
      r_wr_bank <= 1'b0;
      r_wr_addr <= '0;
    end else if (w_hs) begin
      r_wr_en   <= 1'b1;
      r_wr_sel  <= w_side;
      r_wr_bank <= r_load_ptr;
      r_wr_addr <= ADDR_W'(w_cur_cnt);
    end else begin
      r_wr_en   <= 1'b0;
    end
  end

  // Compute FSM state and bank ownership; done flips ownership on the same edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= C_IDLE;
      r_comp_bank <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_done) r_comp_bank <= ~r_comp_bank;
    end
  end

  // Compute FSM next state; start pulses on the cycle the owned bank is full
  always_comb begin
    w_state_nxt  = r_state;
    w_comp_start = 1'b0;
    case (r_state)
      C_IDLE: begin
        if (r_bank_full[r_comp_bank]) begin
          w_state_nxt  = C_RUN;
          w_comp_start = 1'b1;
        end
      end
      C_RUN: begin
        if (bus.comp_done) w_state_nxt = C_IDLE;
      end
      default: w_state_nxt = C_IDLE;
    endcase
  end

  assign bus.wr_en      = r_wr_en;
  assign bus.wr_sel     = r_wr_sel;
  assign bus.wr_bank    = r_wr_bank;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.comp_start = w_comp_start && rst_n;
  assign bus.comp_bank  = r_comp_bank;
  assign bus.comp_busy  = (r_state == C_RUN);
  assign bus.bank_full  = r_bank_full;

endmodule

// File: tb/tb_bank_pingpong_sched.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run, all cross-checked every cycle against a behavioural model
// built from tile counts, a load pointer and a compute-ownership flag.
module tb_bank_pingpong_sched;
  localparam int WD = 4;
  localparam int ND = 4;
  localparam int AW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bank_pingpong_sched_if #(.ADDR_W(AW)) bus();

  bank_pingpong_sched #(.W_DEPTH(WD), .N_DEPTH(ND), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int starts = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_wc[2], m_nc[2];
  int m_lp, m_rr, m_run, m_cb;   // m_rr: 1 = north granted last
  int m_wr_en, m_wr_sel, m_wr_bank, m_wr_addr;
  bit m_ok = 0;

  function automatic bit mfull(input int b);
    return (m_wc[b] == WD) && (m_nc[b] == ND);
  endfunction

  function automatic void exp_grants(output bit gw, output bit gn);
    bit we, ne;
    we = rst_n && bus.w_in_valid && (m_wc[m_lp] < WD);
    ne = rst_n && bus.n_in_valid && (m_nc[m_lp] < ND);
    gw = we && (!ne || m_rr == 1);
    gn = ne && (!we || m_rr == 0);
  endfunction

  always @(posedge clk) begin
    bit gw, gn, fcb, done;
    if (!rst_n) begin
      m_wc = '{0, 0}; m_nc = '{0, 0};
      m_lp = 0; m_rr = 1; m_run = 0; m_cb = 0;
      m_wr_en = 0; m_wr_sel = 0; m_wr_bank = 0; m_wr_addr = 0;
      m_ok = 1;
    end else if (m_ok) begin
      exp_grants(gw, gn);
      fcb  = mfull(m_cb);
      done = bus.comp_done && (m_run != 0);
      if (gw || gn) begin
        m_wr_en = 1; m_wr_sel = gn; m_wr_bank = m_lp;
        if (gn) begin m_wr_addr = m_nc[m_lp]; m_nc[m_lp]++; end
        else    begin m_wr_addr = m_wc[m_lp]; m_wc[m_lp]++; end
        m_rr = gn;
        if (mfull(m_lp)) m_lp ^= 1;
      end else begin
        m_wr_en = 0;
      end
      if (m_run == 0 && fcb) m_run = 1;
      else if (done) begin
        m_wc[m_cb] = 0; m_nc[m_cb] = 0; m_cb ^= 1; m_run = 0;
      end
    end
  end

  // Single compare process, on the falling edge
  always @(negedge clk) begin
    bit gw, gn;
    if (m_ok) begin
      exp_grants(gw, gn);
      chk("w_in_ready", bus.w_in_ready, gw);
      chk("n_in_ready", bus.n_in_ready, gn);
      chk("wr_en",      bus.wr_en,   m_wr_en);
      chk("wr_sel",     bus.wr_sel,  m_wr_sel);
      chk("wr_bank",    bus.wr_bank, m_wr_bank);
      chk("wr_addr",    bus.wr_addr, m_wr_addr);
      chk("comp_bank",  bus.comp_bank, m_cb);
      chk("comp_busy",  bus.comp_busy, m_run);
      chk("bank_full",  bus.bank_full, {mfull(1), mfull(0)});
      chk("comp_start", bus.comp_start, rst_n && m_run == 0 && mfull(m_cb));
      if (bus.comp_start === 1'b1) starts++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drv(input logic wv, input logic nv, input logic cd);
    bus.w_in_valid = wv; bus.n_in_valid = nv; bus.comp_done = cd;
  endtask

  // Waits (bounded) until a negedge with wr_en high
  task automatic wait_wr(input string nm);
    int c;
    for (c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.wr_en === 1'b1) break;
    end
    if (c >= 20) begin
      checks++; errors++;
      $display("FAIL %s timeout waiting for wr_en", nm);
    end
  endtask

  logic [0:7] EXP_SEL;
  int         EXP_ADDR[8];

  initial begin
    EXP_SEL  = 8'b0101_0101;
    EXP_ADDR = '{0, 0, 1, 1, 2, 2, 3, 3};
    drv(1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_w_ready_forced", bus.w_in_ready, 0);
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_bank_full", bus.bank_full, 0);
    chk("rst_comp_busy", bus.comp_busy, 0);

    // Alternating fill of bank 0 then bank 1
    @(posedge clk); #1; rst_n = 1'b1; drv(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      wait_wr($sformatf("seq%0d", i));
      chk($sformatf("seq_sel%0d", i),  bus.wr_sel,  EXP_SEL[i]);
      chk($sformatf("seq_addr%0d", i), bus.wr_addr, EXP_ADDR[i]);
      chk($sformatf("seq_bank%0d", i), bus.wr_bank, 0);
    end
    chk("full0_after8", bus.bank_full[0], 1);
    chk("start_bank0", bus.comp_bank, 0);
    repeat (10) @(negedge clk);
    chk("both_full", bus.bank_full, 2'b11);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("stall_wr_en", bus.wr_en, 0);
      chk("stall_w_ready", bus.w_in_ready, 0);
      chk("stall_n_ready", bus.n_in_ready, 0);
    end
    chk("start_once", starts, 1);

    // Release bank 0 while bank 1 is full
    @(posedge clk); #1; bus.comp_done = 1'b1;
    @(posedge clk); #1; bus.comp_done = 1'b0;
    @(negedge clk);
    chk("rel_bank_full", bus.bank_full, 2'b10);
    chk("rel_comp_bank", bus.comp_bank, 1);
    chk("rel_comp_start", bus.comp_start, 1);
    wait_wr("resume");
    chk("resume_bank", bus.wr_bank, 0);
    chk("resume_addr", bus.wr_addr, 0);
    chk("resume_sel",  bus.wr_sel, 0);

    // Reset after three west writes
    @(posedge clk); #1; rst_n = 1'b0; drv(1'b1, 1'b0, 1'b0);
    @(posedge clk); #1; rst_n = 1'b1;
    for (int i = 0; i < 3; i++) wait_wr("pre_rst");
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1; drv(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("r40_wr_en", bus.wr_en, 0);
    chk("r40_wr_addr", bus.wr_addr, 0);
    chk("r40_comp_bank", bus.comp_bank, 0);
    chk("r40_w_ready", bus.w_in_ready, 1);
    chk("r40_n_ready", bus.n_in_ready, 0);
    wait_wr("post_rst");
    chk("r40_sel", bus.wr_sel, 0);
    chk("r40_addr", bus.wr_addr, 0);
    chk("r40_bank", bus.wr_bank, 0);

    // West only: four writes then stall
    @(posedge clk); #1; rst_n = 1'b0; drv(1'b1, 1'b0, 1'b0);
    @(posedge clk); #1; rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_wr("west_only");
      chk($sformatf("wo_addr%0d", i), bus.wr_addr, i);
      chk($sformatf("wo_sel%0d", i), bus.wr_sel, 0);
    end
    repeat (4) @(negedge clk);
    chk("wo_w_ready", bus.w_in_ready, 0);
    chk("wo_bank_full", bus.bank_full, 0);

    // comp_done while idle is ignored; north then fills from addr 0
    @(posedge clk); #1; bus.comp_done = 1'b1;
    @(posedge clk); #1; bus.comp_done = 1'b0;
    @(negedge clk);
    chk("idle_done_busy", bus.comp_busy, 0);
    chk("idle_done_full", bus.bank_full, 0);
    chk("idle_done_w_ready", bus.w_in_ready, 0);
    @(posedge clk); #1; bus.n_in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_wr("north_fill");
      chk($sformatf("nf_addr%0d", i), bus.wr_addr, i);
      chk($sformatf("nf_sel%0d", i), bus.wr_sel, 1);
    end
    chk("nf_full", bus.bank_full, 2'b01);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      rst_n = ($urandom_range(0, 499) != 0);
      drv($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
          $urandom_range(0, 7) == 0);
    end
    @(posedge clk); #1; drv(1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
